div_ctrl: RTL and testbench

- Iterative radix-2 divider with its own sequencing FSM, placed in the execute stage beside the ALU.
- Serves DIV/DIVU: a start from EX begins a 32-iteration shift-subtract sequence.
- Drives the stall that the hazard unit consumes as div_stallE to freeze F/D/E/M/W until the result is ready.
- Delivers {remainder, quotient} for the HI/LO write path.

---
 rtl/div_ctrl.sv | 75 +++++++
 tb/tb_div_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: iterative radix-2 shift-subtract divider with its own sequencing FSM for DIV/DIVU.
// Stalls the pipeline while busy and presents {remainder, quotient} while ready_o is high.
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stall_o
);
    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
    state_t state, stateNext;
    logic [5:0] cnt;
    logic [2*DATA_W:0] work;
    logic [DATA_W-1:0] divisor, absDividend, absDivisor, diff, quo, rem, quoFix, remFix;
    logic isSigned, dividendNeg, divisorNeg, fits, go;

    assign go = start_i & ~annul_i;
    assign absDividend = (signed_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign absDivisor = (signed_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // Partial remainder occupies work[2W:W]; only the low W bits of the difference survive a subtract.
    assign fits = work[2*DATA_W:DATA_W] >= {1'b0, divisor};
    assign diff = work[2*DATA_W-1:DATA_W] - divisor;
    assign quo = work[DATA_W-1:0];
    assign rem = work[2*DATA_W:DATA_W+1];
    assign quoFix = (isSigned & (dividendNeg ^ divisorNeg)) ? -quo : quo;
    assign remFix = (isSigned & dividendNeg) ? -rem : rem;
    assign ready_o = state == END;
    assign stall_o = start_i & ~ready_o;
    assign result_o = ready_o ? {remFix, quoFix} : '0;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = go ? ((opdata2_i == '0) ? DIVZERO : ON) : IDLE;
            DIVZERO: stateNext = annul_i ? IDLE : END;
            ON:      stateNext = annul_i ? IDLE : ((cnt == 6'(DATA_W - 1)) ? END : ON);
            END:     stateNext = (annul_i | ~start_i) ? IDLE : END;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            work <= '0;
            divisor <= '0;
            isSigned <= 1'b0;
            dividendNeg <= 1'b0;
            divisorNeg <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE && go) begin
                work <= {{DATA_W{1'b0}}, absDividend, 1'b0};
                cnt <= '0;
                divisor <= absDivisor;
                isSigned <= signed_i;
                dividendNeg <= opdata1_i[DATA_W-1];
                divisorNeg <= opdata2_i[DATA_W-1];
            end else if (state == DIVZERO) begin
                work <= '0;
            end else if (state == ON && !annul_i) begin
                work <= fits ? {diff, work[DATA_W-1:0], 1'b1} : work << 1;
                cnt <= cnt + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed-vector bench for div_ctrl; each task drives one scenario and checks inline.
module tb_div_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start_i = 1'b0;
    logic signed_i = 1'b0;
    logic annul_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic ready_o;
    logic stall_o;
    int checks = 0;
    int failures = 0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .result_o(result_o), .ready_o(ready_o),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    // Called at a negedge with the divider idle; start is dropped once the result is seen.
    task automatic doDivide(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic [63:0] res, output int stallBad,
                            output logic postReady, output logic [63:0] postRes);
        signed_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        lat = -1; stallBad = 0; res = '0;
        #1;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~sgn;
            end
            if (ready_o) begin
                lat = c; res = result_o;
                if (stall_o) stallBad++;
                break;
            end
            if (!stall_o) stallBad++;
        end
        start_i = 1'b0;
        @(negedge clk);
        postReady = ready_o; postRes = result_o;
    endtask

    task automatic test_reset;
        resetn = 1'b0; start_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got %b expected 0", ready_o); end
        checks++;
        if (result_o !== 64'h0) begin failures++; $display("FAIL reset_result got %h expected 0", result_o); end
        start_i = 1'b1; #1;
        checks++;
        if (stall_o !== 1'b1) begin failures++; $display("FAIL reset_stall_follows_start got %b expected 1", stall_o); end
        start_i = 1'b0; #1;
        checks++;
        if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got %b expected 0", stall_o); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_basic;
        int lat, stallBad;
        logic [63:0] res, postRes;
        logic postReady;
        doDivide(1'b0, 32'd100, 32'd7, lat, res, stallBad, postReady, postRes);
        checks++;
        if (lat != 33) begin failures++; $display("FAIL divu_100_7_latency got %0d expected 33", lat); end
        checks++;
        if (res !== {32'h2, 32'hE}) begin failures++; $display("FAIL divu_100_7_result got %h expected %h", res, {32'h2, 32'hE}); end
        checks++;
        if (stallBad != 0) begin failures++; $display("FAIL divu_100_7_stall got %0d bad cycles expected 0", stallBad); end
        checks++;
        if (postReady !== 1'b0 || postRes !== 64'h0) begin
            failures++; $display("FAIL divu_100_7_release got ready=%b result=%h expected ready=0 result=0", postReady, postRes);
        end
    endtask

    task automatic test_vectors;
        logic        vSgn [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] vA   [7] = '{32'hFFFFFFF9, 32'h7, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h12345678, 32'hFFFFFF9C};
        logic [31:0] vB   [7] = '{32'h2, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1000, 32'hFFFFFFF9};
        logic [63:0] vRes [7] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h1, 32'hFFFFFFFD}, {32'h0, 32'hFFFFFFFF},
                                  {32'h0, 32'h80000000}, {32'h80000000, 32'h0}, {32'h678, 32'h12345},
                                  {32'hFFFFFFFE, 32'hE}};
        int lat, stallBad;
        logic [63:0] res, postRes;
        logic postReady;
        for (int i = 0; i < 7; i++) begin
            doDivide(vSgn[i], vA[i], vB[i], lat, res, stallBad, postReady, postRes);
            checks++;
            if (lat != 33 || res !== vRes[i]) begin
                failures++;
                $display("FAIL vector%0d %h/%h got lat=%0d result=%h expected lat=33 result=%h", i, vA[i], vB[i], lat, res, vRes[i]);
            end
        end
    endtask

    task automatic test_divzero;
        int lat, stallBad;
        logic [63:0] res, postRes;
        logic postReady;
        doDivide(1'b0, 32'hFFFFFFFF, 32'h0, lat, res, stallBad, postReady, postRes);
        checks++;
        if (lat != 2 || res !== 64'h0) begin
            failures++; $display("FAIL divzero_unsigned got lat=%0d result=%h expected lat=2 result=0", lat, res);
        end
        doDivide(1'b1, 32'hFFFFFFFB, 32'h0, lat, res, stallBad, postReady, postRes);
        checks++;
        if (lat != 2 || res !== 64'h0 || stallBad != 0) begin
            failures++; $display("FAIL divzero_signed got lat=%0d result=%h stallBad=%0d expected lat=2 result=0 stallBad=0", lat, res, stallBad);
        end
    endtask

    task automatic test_annul;
        int lat, stallBad, readyBad;
        logic [63:0] res, postRes;
        logic postReady;
        readyBad = 0;
        signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ready_o) readyBad++;
        end
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        if (ready_o) readyBad++;
        @(negedge clk);
        doDivide(1'b0, 32'd9, 32'd3, lat, res, stallBad, postReady, postRes);
        checks++;
        if (readyBad != 0) begin failures++; $display("FAIL annul_ready_quiet got %0d ready cycles expected 0", readyBad); end
        checks++;
        if (lat != 33 || res !== {32'h0, 32'h3}) begin
            failures++; $display("FAIL annul_restart got lat=%0d result=%h expected lat=33 result=%h", lat, res, {32'h0, 32'h3});
        end
    endtask

    task automatic test_annul_end;
        int k;
        signed_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd4; start_i = 1'b1;
        k = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready_o) begin k = c; break; end
        end
        @(negedge clk);
        checks++;
        if (k != 33 || ready_o !== 1'b1 || result_o !== {32'h0, 32'h5}) begin
            failures++; $display("FAIL end_hold got lat=%0d ready=%b result=%h expected lat=33 ready=1 result=%h", k, ready_o, result_o, {32'h0, 32'h5});
        end
        annul_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            failures++; $display("FAIL end_annul got ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
        end
        annul_i = 1'b0; start_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int k;
        signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (20) @(negedge clk);
        resetn = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0 || stall_o !== 1'b1) begin
            failures++; $display("FAIL reset_mid_state got ready=%b result=%h stall=%b expected ready=0 result=0 stall=1", ready_o, result_o, stall_o);
        end
        resetn = 1'b1;
        k = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ready_o) begin k = c; break; end
        end
        checks++;
        if (k != 33 || result_o !== {32'h0, 32'hA}) begin
            failures++; $display("FAIL reset_mid_restart got lat=%0d result=%h expected lat=33 result=%h", k, result_o, {32'h0, 32'hA});
        end
        start_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_divu_basic;
        test_vectors;
        test_divzero;
        test_annul;
        test_annul_end;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
